// File: rtl/conv_sched.sv
// conv_sched: frame-level scheduler for the 3x3 convolution datapath.
// Walks the image in raster order, issuing one 3-row column read per cycle.
// It also delays the read strobe into the pixel-unit enable and keeps only
// the pixel-unit outputs that are real output pixels (not row window-fill).
// Optional feature macro: CONV_SCHED_PERF_EN adds the perf_cycles counter
// (start-to-done cycle count).
module conv_sched #(
  parameter int XB      = 10,
  parameter int YB      = 10,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XB-1:0] img_w,
  input  logic [YB-1:0] img_h,
  input  logic          hold,
  output logic          rd_en,
  output logic [XB-1:0] rd_x,
  output logic [YB-1:0] rd_y,
  output logic          pu_en,
  input  logic          pu_valid,
  output logic          pix_keep,
  output logic          busy,
  output logic          proc_done,
  output logic          cfg_err
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  localparam int KW = XB + YB;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [XB-1:0]      w_q, w_d;
  logic [YB-1:0]      h_q, h_d;
  logic [XB-1:0]      x_q, x_d;
  logic [YB-1:0]      y_q, y_d;
  logic [XB-1:0]      rc_q, rc_d;
  logic [YB-1:0]      rr_q, rr_d;
  logic [KW-1:0]      kept_q, kept_d;
  logic [MEM_LAT-1:0] dly_q, dly_d;
  logic               cfg_err_q, cfg_err_d;
  logic [KW-1:0]      target;
  logic               size_ok;
  logic               active;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0]        perf_q, perf_d;
`endif

  // Outputs decoded directly from state so hold can gate a read in its own cycle.
  assign active    = (state_q != S_IDLE);
  assign rd_en     = (state_q == S_ISSUE) && !hold;
  assign rd_x      = rd_en ? x_q : '0;
  assign rd_y      = rd_en ? y_q : '0;
  assign pu_en     = dly_q[MEM_LAT-1];
  assign pix_keep  = active && pu_valid && (rc_q >= XB'(2));
  assign busy      = active;
  assign proc_done = (state_q == S_DONE);
  assign cfg_err   = cfg_err_q;
  assign size_ok   = (img_w >= XB'(3)) && (img_h >= YB'(3));
  // Number of output pixels in a frame: (w-2)*(h-2).
  assign target    = (KW'(w_q) - KW'(2)) * (KW'(h_q) - KW'(2));
`ifdef CONV_SCHED_PERF_EN
  assign perf_cycles = perf_q;
`endif

  // Next-state logic: read walker, delay line, output qualification and FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    x_d       = x_q;
    y_d       = y_q;
    rc_d      = rc_q;
    rr_d      = rr_q;
    kept_d    = kept_q;
    dly_d     = dly_q;
    cfg_err_d = 1'b0;
`ifdef CONV_SCHED_PERF_EN
    perf_d    = perf_q;
`endif

    // Outside IDLE the delay line shifts and pixel-unit outputs are qualified.
    if (active) begin
      dly_d = MEM_LAT'({dly_q, rd_en});
`ifdef CONV_SCHED_PERF_EN
      perf_d = perf_q + 32'd1;
`endif
      if (pu_valid) begin
        if (pix_keep) kept_d = kept_q + KW'(1);
        if (rc_q == w_q - XB'(1)) begin
          rc_d = '0;
          rr_d = rr_q + YB'(1);
        end else begin
          rc_d = rc_q + XB'(1);
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d = img_w;
          h_d = img_h;
          if (!size_ok) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            x_d     = '0;
            y_d     = '0;
            rc_d    = '0;
            rr_d    = '0;
            kept_d  = '0;
`ifdef CONV_SCHED_PERF_EN
            // The start cycle itself counts toward the frame time.
            perf_d  = 32'd1;
`endif
          end
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          if (x_q == w_q - XB'(1)) begin
            x_d = '0;
            if (y_q == h_q - YB'(3)) state_d = S_DRAIN;
            else                     y_d     = y_q + YB'(1);
          end else begin
            x_d = x_q + XB'(1);
          end
        end
      end
      S_DRAIN: begin
        // Using the next count makes proc_done land one cycle after the last keep.
        if (kept_d == target) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rc_q      <= '0;
      rr_q      <= '0;
      kept_q    <= '0;
      dly_q     <= '0;
      cfg_err_q <= 1'b0;
`ifdef CONV_SCHED_PERF_EN
      perf_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rc_q      <= rc_d;
      rr_q      <= rr_d;
      kept_q    <= kept_d;
      dly_q     <= dly_d;
      cfg_err_q <= cfg_err_d;
`ifdef CONV_SCHED_PERF_EN
      perf_q    <= perf_d;
`endif
    end
  end

endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed self-checking bench for conv_sched (MEM_LAT=1).
// The pixel unit is modelled as a 2-cycle delay from pu_en to pu_valid.
module tb_conv_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] img_w = '0;
  logic [9:0] img_h = '0;
  logic       hold = 1'b0;
  logic       rd_en;
  logic [9:0] rd_x;
  logic [9:0] rd_y;
  logic       pu_en;
  logic       pu_valid;
  logic       pix_keep;
  logic       busy;
  logic       proc_done;
  logic       cfg_err;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  conv_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .img_w     (img_w),
    .img_h     (img_h),
    .hold      (hold),
    .rd_en     (rd_en),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .pu_en     (pu_en),
    .pu_valid  (pu_valid),
    .pix_keep  (pix_keep),
    .busy      (busy),
    .proc_done (proc_done),
    .cfg_err   (cfg_err)
`ifdef CONV_SCHED_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Pixel-unit model and cycle counter.
  int         cyc = 0;
  logic [1:0] pu_pipe = '0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    pu_pipe <= {pu_pipe[0], pu_en};
  end
  assign pu_valid = pu_pipe[1];

  // Monitor: samples at the falling edge and logs events.
  int   rd_xq[$];
  int   rd_yq[$];
  int   rd_cq[$];
  int   n_keep = 0, n_valid = 0, n_done = 0, n_cfg = 0, n_busy = 0;
  int   last_keep_c = 0, done_c = 0, cfg_c = 0;
  int   pu_bad = 0, addr_bad = 0;
  int   n_rst = 0, rst_seen = 0;
  logic rd_en_prev = 1'b0;

  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      rd_xq.push_back(int'(rd_x));
      rd_yq.push_back(int'(rd_y));
      rd_cq.push_back(cyc);
    end
    if (pix_keep === 1'b1) begin n_keep++; last_keep_c = cyc; end
    if (pu_valid === 1'b1) n_valid++;
    if (proc_done === 1'b1) begin n_done++; done_c = cyc; end
    if (cfg_err === 1'b1) begin n_cfg++; cfg_c = cyc; end
    if (busy === 1'b1) n_busy++;
    if (rst || n_rst != rst_seen) rst_seen = n_rst;
    else if (pu_en !== rd_en_prev) pu_bad++;
    if (rd_en !== 1'b1 && (rd_x !== '0 || rd_y !== '0)) addr_bad++;
    rd_en_prev = rd_en;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int s_c      = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start pulse; s_c records the cycle it is presented in.
  task automatic pulse_start(input int w, input int h);
    img_w = 10'(w);
    img_h = 10'(h);
    start = 1'b1;
    s_c   = cyc;
    tick(1);
    start = 1'b0;
  endtask

  // Wait for exactly one proc_done, bounded; lands in the cycle after DONE.
  task automatic wait_done(input string tag, input int budget);
    int d0 = n_done;
    int k  = 0;
    while (n_done == d0 && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, "_done_seen"}, n_done - d0, 1);
    tick(1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  // Read order must be raster order over w columns starting at log index base.
  task automatic check_seq(input string tag, input int base, input int n, input int w);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (rd_xq[base+i] != i % w || rd_yq[base+i] != i / w) bad++;
    end
    check(tag, bad, 0);
  endtask

  int rb, kb, vb, cb, bb;

  initial begin
    // Reset state.
    tick(2);
    check("reset_outputs", {rd_en, pu_en, busy, proc_done, cfg_err, pix_keep}, 0);
    check("reset_addr", {rd_x, rd_y}, 0);
    rst = 1'b0;
    tick(2);

    // 3x3 frame: 3 reads, 1 kept pixel.
    rb = rd_xq.size(); kb = n_keep;
    pulse_start(3, 3);
    wait_done("f3x3", 50);
    check("f3x3_reads", rd_xq.size() - rb, 3);
    check_seq("f3x3_seq", rb, 3, 3);
    check("f3x3_first_rd", rd_cq[rb] - s_c, 1);
    check("f3x3_keeps", n_keep - kb, 1);
    check("f3x3_keep_cyc", last_keep_c - s_c, 6);
    check("f3x3_done_cyc", done_c - s_c, 7);
    tick(2);

    // Illegal size: cfg_err pulse, no reads, never busy.
    rb = rd_xq.size(); cb = n_cfg; bb = n_busy;
    pulse_start(2, 5);
    tick(3);
    check("ill_cfg_err", n_cfg - cb, 1);
    check("ill_cfg_cyc", cfg_c - s_c, 1);
    check("ill_reads", rd_xq.size() - rb, 0);
    check("ill_busy", n_busy - bb, 0);

    // 8x5 frame: 24 seamless reads, 18 kept pixels.
    rb = rd_xq.size(); kb = n_keep; vb = n_valid; bb = n_busy;
    pulse_start(8, 5);
    wait_done("f8x5", 200);
    check("f8x5_reads", rd_xq.size() - rb, 24);
    check_seq("f8x5_seq", rb, 24, 8);
    check("f8x5_row_y2", rd_yq[rb+16], 2);
    check("f8x5_seamless", rd_cq[rb+23] - rd_cq[rb], 23);
    check("f8x5_valids", n_valid - vb, 24);
    check("f8x5_keeps", n_keep - kb, 18);
    check("f8x5_done_after_keep", done_c - last_keep_c, 1);
    check("f8x5_done_cyc", done_c - s_c, 28);
    check("f8x5_busy_cycles", n_busy - bb, 28);
    tick(2);

    // 6x3 reference frame without hold.
    rb = rd_xq.size(); kb = n_keep;
    pulse_start(6, 3);
    wait_done("f6x3", 100);
    check("f6x3_keeps", n_keep - kb, 4);
    check("f6x3_done_cyc", done_c - s_c, 10);
`ifdef CONV_SCHED_PERF_EN
    check("f6x3_perf", perf_cycles, 11);
`endif
    tick(2);

    // Same frame with hold for 4 cycles where x=3 would issue.
    rb = rd_xq.size(); kb = n_keep;
    pulse_start(6, 3);
    tick(3);
    hold = 1'b1;
    tick(4);
    hold = 1'b0;
    wait_done("hold", 100);
    check("hold_reads", rd_xq.size() - rb, 6);
    check_seq("hold_seq", rb, 6, 6);
    check("hold_gap", rd_cq[rb+3] - rd_cq[rb+2], 5);
    check("hold_keeps", n_keep - kb, 4);
    check("hold_done_cyc", done_c - s_c, 14);
`ifdef CONV_SCHED_PERF_EN
    check("hold_perf", perf_cycles, 15);
`endif
    tick(2);

    // Reset mid-ISSUE; in-flight pixel-unit outputs must be ignored.
    pulse_start(8, 5);
    tick(4);
    vb = n_valid; kb = n_keep;
    n_rst++;
    rst = 1'b1;
    #1;
    check("rst_outputs", {rd_en, pu_en, busy, proc_done, cfg_err, pix_keep}, 0);
    check("rst_addr", {rd_x, rd_y}, 0);
    #1;
    rst = 1'b0;
    tick(6);
    check("rst_idle_valid_seen", (n_valid - vb) > 1, 1);
    check("rst_idle_no_keep", n_keep - kb, 0);

    // 4x4 frame after reset completes normally.
    rb = rd_xq.size(); kb = n_keep;
    pulse_start(4, 4);
    wait_done("f4x4", 100);
    check("f4x4_reads", rd_xq.size() - rb, 8);
    check_seq("f4x4_seq", rb, 8, 4);
    check("f4x4_keeps", n_keep - kb, 4);
    check("f4x4_done_cyc", done_c - s_c, 12);
    tick(2);

    // start while busy is ignored; original 4x4 size is kept.
    rb = rd_xq.size(); kb = n_keep; cb = n_cfg;
    pulse_start(4, 4);
    tick(2);
    img_w = 10'd8;
    img_h = 10'd5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("busy_start", 100);
    tick(5);
    check("busy_start_reads", rd_xq.size() - rb, 8);
    check_seq("busy_start_seq", rb, 8, 4);
    check("busy_start_keeps", n_keep - kb, 4);
    check("busy_start_cfg", n_cfg - cb, 0);

    // Whole-run invariants from the monitor.
    check("pu_en_tracks_rd_en", pu_bad, 0);
    check("addr_zero_when_idle", addr_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
